// File: rtl/led_pwm_blink_driver_if.sv
// LED driver bus: CPU-side PIO words in, registered LED pin drive and status out.
// The driver takes the slave side; whoever owns the PIO words takes the master side.
interface led_pwm_blink_driver_if #(
  parameter int PWM_BITS = 4
);
  logic [9:0]          led_word;
  logic [9:0]          blink_mask;
  logic [PWM_BITS-1:0] brightness;
  logic [9:0]          ledr;
  logic                blink_phase;
  logic                led_changed;

  modport master (
    output led_word, blink_mask, brightness,
    input  ledr, blink_phase, led_changed
  );

  modport slave (
    input  led_word, blink_mask, brightness,
    output ledr, blink_phase, led_changed
  );
endinterface

// File: rtl/led_pwm_blink_driver.sv
// Drives LEDR[9:0] from the LED PIO word with per-LED blink and global PWM dimming.
// PIO inputs are shadowed only at PWM period boundaries so a write never tears a cycle.
module led_pwm_blink_driver #(
  parameter int PWM_BITS   = 4,
  parameter int BLINK_HALF = 12500000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  led_pwm_blink_driver_if.slave bus
);

  localparam int                  BLINK_W    = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;
  localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [9:0]          word_q, word_d;
  logic [9:0]          mask_q, mask_d;
  logic [PWM_BITS-1:0] bright_q, bright_d;
  logic [9:0]          ledr_q, ledr_d;
  logic                led_changed_q, led_changed_d;

  logic                shadow_load;
  logic                pwm_on;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      word_q        <= '0;
      mask_q        <= '0;
      bright_q      <= '0;
      ledr_q        <= '0;
      led_changed_q <= 1'b0;
    end else begin
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      word_q        <= word_d;
      mask_q        <= mask_d;
      bright_q      <= bright_d;
      ledr_q        <= ledr_d;
      led_changed_q <= led_changed_d;
    end
  end

  always_comb begin
    pwm_cnt_d   = pwm_cnt_q + 1'b1;
    shadow_load = (pwm_cnt_q == PWM_MAX);

    word_d        = word_q;
    mask_d        = mask_q;
    bright_d      = bright_q;
    led_changed_d = 1'b0;
    if (shadow_load) begin
      word_d        = bus.led_word;
      mask_d        = bus.blink_mask;
      bright_d      = bus.brightness;
      led_changed_d = (bus.led_word != word_q);
    end
  end

  // Blink timebase is free-running; shadow loads and PWM never disturb it.
  always_comb begin
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_comb begin
    pwm_on = (bright_q == PWM_MAX) || (pwm_cnt_q < bright_q);
    ledr_d = word_q & {10{pwm_on}} & (~mask_q | {10{blink_phase_q}});
  end

  assign bus.ledr        = ledr_q;
  assign bus.blink_phase = blink_phase_q;
  assign bus.led_changed = led_changed_q;

endmodule

// File: tb/tb_led_pwm_blink_driver.sv
// Randomized and directed checks of led_pwm_blink_driver against a cycle-count
// reference model derived from the period/half-period arithmetic.
module tb_led_pwm_blink_driver;
  localparam int PWM_BITS   = 4;
  localparam int PERIOD     = 1 << PWM_BITS;
  localparam int BLINK_HALF = 8;
  localparam int MAXB       = PERIOD - 1;

  logic clk;
  logic reset_n;

  led_pwm_blink_driver_if #(.PWM_BITS(PWM_BITS)) bus ();

  led_pwm_blink_driver #(
    .PWM_BITS  (PWM_BITS),
    .BLINK_HALF(BLINK_HALF)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int chg_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: m_n counts clock edges since reset release, so the PWM
  // position is m_n mod PERIOD and the blink phase flips every BLINK_HALF edges.
  int         m_n;
  logic [9:0] m_word, m_mask, m_ledr;
  int         m_bright;
  logic       m_chg;

  function automatic logic model_phase(input int n);
    return ((n / BLINK_HALF) % 2) == 0;
  endfunction

  function automatic logic [9:0] model_ledr(input int n, input logic [9:0] w,
                                            input logic [9:0] m, input int b);
    int   pos;
    logic on;
    pos = n % PERIOD;
    on  = (b == MAXB) || (pos < b);
    if (!on) return 10'h000;
    return w & (model_phase(n) ? 10'h3FF : ~m);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_n      <= 0;
      m_word   <= '0;
      m_mask   <= '0;
      m_bright <= 0;
      m_ledr   <= '0;
      m_chg    <= 1'b0;
    end else begin
      m_n    <= m_n + 1;
      m_ledr <= model_ledr(m_n, m_word, m_mask, m_bright);
      if ((m_n % PERIOD) == PERIOD - 1) begin
        m_word   <= bus.led_word;
        m_mask   <= bus.blink_mask;
        m_bright <= int'(bus.brightness);
        m_chg    <= (bus.led_word != m_word);
      end else begin
        m_chg <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    check("ledr", 32'(bus.ledr), 32'(m_ledr));
    check("blink_phase", 32'(bus.blink_phase), 32'(model_phase(m_n)));
    check("led_changed", 32'(bus.led_changed), 32'(m_chg));
    chg_cnt += int'(bus.led_changed);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic drive(input logic [9:0] w, input logic [9:0] m, input logic [3:0] b);
    bus.led_word   = w;
    bus.blink_mask = m;
    bus.brightness = b;
  endtask

  // Advance until the DUT's pwm_cnt will hold value p during the coming cycle.
  task automatic go_to_pos(input int p);
    for (int i = 0; i < PERIOD; i++) begin
      if ((m_n % PERIOD) == p) return;
      tick();
    end
    check("go_to_pos_timeout", 32'(m_n % PERIOD), 32'(p));
  endtask

  int on_cnt;

  initial begin
    reset_n = 1'b0;
    drive(10'h3FF, 10'h000, 4'hF);
    repeat (3) @(negedge clk);
    check("reset_ledr", 32'(bus.ledr), 32'h0);
    check("reset_phase", 32'(bus.blink_phase), 32'h1);
    check("reset_changed", 32'(bus.led_changed), 32'h0);
    reset_n = 1'b1;

    // Full brightness, no blink: dark for the first period, then 0x3FF.
    chg_cnt = 0;
    run(PERIOD);
    check("first_period_dark", 32'(bus.ledr), 32'h0);
    run(PERIOD * 2);
    check("full_on", 32'(bus.ledr), 32'h3FF);
    check("first_load_pulses", 32'(chg_cnt), 32'h1);

    // Half duty.
    drive(10'h2A5, 10'h000, 4'h8);
    run(PERIOD * 3);

    // Brightness 0 then 1: exactly one lit cycle per period.
    drive(10'h3FF, 10'h000, 4'h0);
    run(PERIOD * 2);
    drive(10'h3FF, 10'h000, 4'h1);
    run(PERIOD * 2);
    on_cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      if (bus.ledr == 10'h3FF) on_cnt++;
    end
    check("bright1_on_cycles", 32'(on_cnt), 32'h1);

    // Blink on bit 0 while bit 9 stays steady.
    drive(10'h201, 10'h001, 4'hF);
    run(PERIOD * 4);

    // Mid-period word change: held off until the wrap, one led_changed pulse.
    drive(10'h001, 10'h000, 4'hF);
    run(PERIOD * 2);
    go_to_pos(5);
    chg_cnt = 0;
    drive(10'h002, 10'h000, 4'hF);
    run(PERIOD - 5);
    check("no_early_apply", 32'(bus.ledr), 32'h001);
    run(PERIOD);
    check("applied_after_wrap", 32'(bus.ledr), 32'h002);
    check("mid_change_pulses", 32'(chg_cnt), 32'h1);

    // Asynchronous reset mid-period while lit.
    drive(10'h3FF, 10'h000, 4'hF);
    run(PERIOD * 2);
    go_to_pos(9);
    check("pre_reset_ledr", 32'(bus.ledr), 32'h3FF);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_ledr", 32'(bus.ledr), 32'h0);
    check("async_reset_phase", 32'(bus.blink_phase), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    run(PERIOD);
    check("post_reset_dark", 32'(bus.ledr), 32'h0);
    run(2);
    check("post_reset_recover", 32'(bus.ledr), 32'h3FF);

    // Random segments, including changes landing right at the load edge.
    for (int s = 0; s < 40; s++) begin
      drive(10'($urandom), 10'($urandom), 4'($urandom));
      run(int'($urandom_range(1, 40)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
